// File: rtl/snes_multi_poller.sv
// -----------------------------------------------------------------------------
// snes_multi_poller
//   Polls NUM_PADS SNES-style game pads in parallel. All pads share one
//   protocol clock and one latch line. Each pad has its own serial data line.
//   A frame starts on the periodic poll tick (when poll_en_i is set) or on a
//   poll_now_i request. A frame runs latch -> BITS shift bits -> commit. At
//   commit the block publishes the per-pad button state, the press/release
//   edge pulses and a connection flag, all together.
//
// Ports
//   clock_i          system clock
//   reset_i          asynchronous active-high reset
//   poll_en_i        allow automatic polling on the period tick
//   poll_now_i       single-cycle request for an immediate poll
//   con_serial_i     per-pad serial data, raw 0 = pressed
//   con_clock_o      shared protocol clock (idles high)
//   con_latch_o      shared latch (idles low)
//   busy_o           frame in progress (LATCH/SHIFT/COMMIT)
//   con_state_o      pad p at [p*BITS +: BITS], active-high buttons
//   con_pressed_o    single-cycle pulse per bit that went 0->1
//   con_released_o   single-cycle pulse per bit that went 1->0
//   con_connected_o  pad p returned a raw frame that was not all-zero
//   frame_valid_o    single-cycle pulse when new outputs are presented
// -----------------------------------------------------------------------------
module snes_multi_poller #(
   parameter int NUM_PADS    = 2,
   parameter int BITS        = 16,
   parameter int POLL_PERIOD = 833333,
   parameter int HALF_PERIOD = 300
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     poll_en_i,
   input  logic                     poll_now_i,
   input  logic [NUM_PADS-1:0]      con_serial_i,
   output logic                     con_clock_o,
   output logic                     con_latch_o,
   output logic                     busy_o,
   output logic [NUM_PADS*BITS-1:0] con_state_o,
   output logic [NUM_PADS*BITS-1:0] con_pressed_o,
   output logic [NUM_PADS*BITS-1:0] con_released_o,
   output logic [NUM_PADS-1:0]      con_connected_o,
   output logic                     frame_valid_o
);

   localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int HW = $clog2(HALF_PERIOD);
   localparam int KW = $clog2(BITS + 1);
   localparam int VW = NUM_PADS * BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LATCH,
      S_SHIFT,
      S_COMMIT
   } state_t;

   // ------------------------------------------------------------------
   // Free-running period counter, independent of the frame FSM
   // ------------------------------------------------------------------
   logic [PW-1:0] per_q, per_d;
   logic          poll_tick;

   assign poll_tick = (per_q == PW'(POLL_PERIOD - 1));
   assign per_d     = poll_tick ? '0 : per_q + 1'b1;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) per_q <= '0;
      else         per_q <= per_d;
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // The latch pulse lasts two half-periods, so LATCH reuses the
   // half-period counter together with the phase bit.
   // In SHIFT, phase 0 is the high half and phase 1 is the low half.
   // ------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [HW-1:0] h_q, h_d;
   logic          ph_q, ph_d;
   logic [KW-1:0] k_q, k_d;
   logic          start;
   logic          last_h;
   logic          capture;
   logic          commit;

   assign start  = (poll_tick & poll_en_i) | poll_now_i;
   assign last_h = (h_q == HW'(HALF_PERIOD - 1));

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         h_q     <= '0;
         ph_q    <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         ph_q    <= ph_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      ph_d        = ph_q;
      k_d         = k_q;
      capture     = 1'b0;
      commit      = 1'b0;
      con_clock_o = 1'b1;
      con_latch_o = 1'b0;
      busy_o      = 1'b1;

      case (state_q)
         S_IDLE: begin
            busy_o = 1'b0;
            // start outside IDLE is simply not looked at, so it is never queued
            if (start) begin
               state_d = S_LATCH;
               h_d     = '0;
               ph_d    = 1'b0;
               k_d     = '0;
            end
         end

         S_LATCH: begin
            con_latch_o = 1'b1;
            if (last_h) begin
               h_d = '0;
               if (ph_q) begin
                  state_d = S_SHIFT;
                  ph_d    = 1'b0;
                  k_d     = '0;
               end else begin
                  ph_d = 1'b1;
               end
            end else begin
               h_d = h_q + 1'b1;
            end
         end

         S_SHIFT: begin
            con_clock_o = ~ph_q;
            if (last_h) begin
               h_d = '0;
               if (!ph_q) begin
                  // Sample at the very end of the high half, just before the falling edge
                  capture = 1'b1;
                  ph_d    = 1'b1;
               end else begin
                  ph_d = 1'b0;
                  if (k_q == KW'(BITS - 1)) state_d = S_COMMIT;
                  else                      k_d     = k_q + 1'b1;
               end
            end else begin
               h_d = h_q + 1'b1;
            end
         end

         S_COMMIT: begin
            commit  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Raw capture: bit k of every pad is taken at the same moment
   // ------------------------------------------------------------------
   logic [VW-1:0] raw_q, raw_d;

   always_comb begin
      raw_d = raw_q;
      if (capture) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            for (int b = 0; b < BITS; b++) begin
               if (k_q == KW'(b)) raw_d[p*BITS + b] = con_serial_i[p];
            end
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) raw_q <= '0;
      else         raw_q <= raw_d;
   end

   // ------------------------------------------------------------------
   // Per-pad commit arithmetic
   // An all-zero raw frame means no pad is driving the line. That pad's
   // state is forced to 0, so anything held shows up as a release.
   // ------------------------------------------------------------------
   logic [VW-1:0]       state_q_v;
   logic [VW-1:0]       new_state;
   logic [VW-1:0]       new_pressed;
   logic [VW-1:0]       new_released;
   logic [NUM_PADS-1:0] new_conn;

   for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic [BITS-1:0] pad_raw;
      logic [BITS-1:0] pad_old;
      logic [BITS-1:0] pad_new;
      logic            pad_conn;

      assign pad_raw  = raw_q[gi*BITS +: BITS];
      assign pad_old  = state_q_v[gi*BITS +: BITS];
      assign pad_conn = |pad_raw;
      assign pad_new  = pad_conn ? ~pad_raw : '0;

      assign new_state[gi*BITS +: BITS]    = pad_new;
      assign new_pressed[gi*BITS +: BITS]  = pad_new & ~pad_old;
      assign new_released[gi*BITS +: BITS] = ~pad_new & pad_old;
      assign new_conn[gi]                  = pad_conn;
   end

   // ------------------------------------------------------------------
   // Output registers: all outputs change together, in the cycle after COMMIT
   // ------------------------------------------------------------------
   logic [VW-1:0]       pressed_q;
   logic [VW-1:0]       released_q;
   logic [NUM_PADS-1:0] conn_q;
   logic                fv_q;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q_v  <= '0;
         pressed_q  <= '0;
         released_q <= '0;
         conn_q     <= '0;
         fv_q       <= 1'b0;
      end else if (commit) begin
         state_q_v  <= new_state;
         pressed_q  <= new_pressed;
         released_q <= new_released;
         conn_q     <= new_conn;
         fv_q       <= 1'b1;
      end else begin
         pressed_q  <= '0;
         released_q <= '0;
         fv_q       <= 1'b0;
      end
   end

   assign con_state_o     = state_q_v;
   assign con_pressed_o   = pressed_q;
   assign con_released_o  = released_q;
   assign con_connected_o = conn_q;
   assign frame_valid_o   = fv_q;

endmodule
